// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM states, owner
// encoding and the memory address/data width.
package mem_arbiter_pkg;

    localparam int MEM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory port plus the fairness state.
// Default build: data has fixed priority, bounded by STARVE_LIMIT
// consecutive contested data grants.
// With MEM_ARB_RR_EN defined: round-robin between the two requesters,
// data preferred first after reset.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    output logic winner,
    output logic fire
);

    logic contested_s;
    logic winner_s;
    logic fire_s;

`ifdef MEM_ARB_RR_EN
    logic last_r;

    // Contested grants alternate; uncontested grants go to the lone requester.
    always_comb begin
        contested_s = if_req & d_req;
        fire_s      = arb_en & (if_req | d_req);
        if (contested_s) begin
            winner_s = ~last_r;
        end else begin
            winner_s = d_req ? OWN_D : OWN_IF;
        end
    end

    // Remember the owner of the most recent grant (fetch after reset, so data wins first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= OWN_IF;
        end else if (fire_s) begin
            last_r <= winner_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_r;
    logic       starve_hit_s;

    // Data wins unless fetch has been passed over LIMIT times in a row.
    always_comb begin
        contested_s  = if_req & d_req;
        fire_s       = arb_en & (if_req | d_req);
        starve_hit_s = (starve_cnt_r >= LIMIT);
        if (contested_s) begin
            winner_s = starve_hit_s ? OWN_IF : OWN_D;
        end else begin
            winner_s = d_req ? OWN_D : OWN_IF;
        end
    end

    // Count data grants taken while fetch was waiting; any other grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
        end else if (fire_s && (winner_s == OWN_D) && if_req) begin
            starve_cnt_r <= (starve_cnt_r == 4'd15) ? 4'd15 : starve_cnt_r + 4'd1;
        end else if (fire_s) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    assign winner = winner_s;
    assign fire   = fire_s;

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the unified 256x8 program/data memory. Serialises
// fetch and load/store traffic through IDLE -> ACCESS -> RESP, drives the
// memory strobes from registers and returns read data with a valid pulse.
// Arbitration policy is selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES  = 0,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [MEM_W-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_valid,
    output logic [MEM_W-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [MEM_W-1:0] d_addr,
    input  logic [MEM_W-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_valid,
    output logic [MEM_W-1:0] d_rdata,
    output logic [MEM_W-1:0] mem_addr,
    output logic [MEM_W-1:0] mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [MEM_W-1:0] mem_rdata,
    output logic             busy
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);

    state_t           state_r;
    logic             own_r;
    logic             we_r;
    logic [7:0]       wait_cnt_r;
    logic             winner_s;
    logic             fire_s;
    logic             grant_s;
    logic             sel_we_s;
    logic [MEM_W-1:0] sel_addr_s;
    logic [MEM_W-1:0] sel_wdata_s;
    logic             last_s;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .arb_en (state_r == ST_IDLE),
        .winner (winner_s),
        .fire   (fire_s)
    );

    // Grant is combinational in IDLE; gated by rst_n so nothing leaks during reset.
    always_comb begin
        grant_s = fire_s & rst_n;
        last_s  = (wait_cnt_r == WAIT_LAST);
        if (winner_s == OWN_D) begin
            sel_we_s    = d_we;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = if_addr;
            sel_wdata_s = {MEM_W{1'b0}};
        end
    end

    assign if_gnt = grant_s & (winner_s == OWN_IF);
    assign d_gnt  = grant_s & (winner_s == OWN_D);

    // Transaction FSM; all memory strobes and response outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            own_r      <= OWN_IF;
            we_r       <= 1'b0;
            wait_cnt_r <= 8'd0;
            mem_addr   <= {MEM_W{1'b0}};
            mem_wdata  <= {MEM_W{1'b0}};
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= {MEM_W{1'b0}};
            d_valid    <= 1'b0;
            d_rdata    <= {MEM_W{1'b0}};
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                    if_rdata <= {MEM_W{1'b0}};
                    d_rdata  <= {MEM_W{1'b0}};
                    if (grant_s) begin
                        state_r    <= ST_ACCESS;
                        busy       <= 1'b1;
                        own_r      <= winner_s;
                        we_r       <= sel_we_s;
                        wait_cnt_r <= 8'd0;
                        mem_addr   <= sel_addr_s;
                        mem_wdata  <= sel_wdata_s;
                        mem_rd     <= ~sel_we_s;
                        mem_wr     <= sel_we_s & (WAIT_LAST == 8'd0);
                    end else begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        mem_addr  <= {MEM_W{1'b0}};
                        mem_wdata <= {MEM_W{1'b0}};
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (last_s) begin
                        state_r   <= ST_RESP;
                        mem_addr  <= {MEM_W{1'b0}};
                        mem_wdata <= {MEM_W{1'b0}};
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        if (own_r == OWN_D) begin
                            d_valid <= 1'b1;
                            d_rdata <= we_r ? {MEM_W{1'b0}} : mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        mem_wr     <= we_r & ((wait_cnt_r + 8'd1) == WAIT_LAST);
                    end
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                    if_rdata <= {MEM_W{1'b0}};
                    d_rdata  <= {MEM_W{1'b0}};
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    mem_addr  <= {MEM_W{1'b0}};
                    mem_wdata <= {MEM_W{1'b0}};
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    if_valid  <= 1'b0;
                    d_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts
// grants, memory strobes and responses; a monitor compares every cycle.
module tb_mem_arbiter;

    localparam int W  = 0;
    localparam int SL = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       if_req, if_gnt, if_valid;
    logic [7:0] if_addr, if_rdata;
    logic       d_req, d_we, d_gnt, d_valid;
    logic [7:0] d_addr, d_wdata, d_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_rd, mem_wr, busy;

    // second instance, WAIT_CYCLES=2
    logic       if_req2, if_gnt2, if_valid2;
    logic [7:0] if_addr2, if_rdata2;
    logic       d_req2, d_we2, d_gnt2, d_valid2;
    logic [7:0] d_addr2, d_wdata2, d_rdata2;
    logic [7:0] mem_addr2, mem_wdata2, mem_rdata2;
    logic       mem_rd2, mem_wr2, busy2;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(SL)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req2), .if_addr(if_addr2), .if_gnt(if_gnt2), .if_valid(if_valid2), .if_rdata(if_rdata2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_gnt(d_gnt2), .d_valid(d_valid2), .d_rdata(d_rdata2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    logic [7:0] mem [256];
    logic [7:0] mem2 [256];
    logic [7:0] ref_mem [256];

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem2[mem_addr2];

    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit         own;   // 1 = data port
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] expd;
        int         g;     // grant cycle
    } txn_t;

    txn_t q[$];
    bit   glog[$];
    int   free_at = 0;
    int   starve_m = 0;
    bit   last_m = 1'b0;

    // Reset drops everything in flight; the model forgets it too.
    always @(negedge rst_n) begin
        q.delete();
        free_at  = 0;
        starve_m = 0;
        last_m   = 1'b0;
    end

    // Monitor: compare DUT against the transaction model every cycle.
    always @(negedge clk) begin : mon
        int         c;
        bit         e_rd, e_wr, e_busy, e_ifv, e_dv, w, gexp;
        logic [7:0] e_addr, e_ifd, e_dd;
        txn_t       t;
        if (rst_n === 1'b1) begin
            c = cyc;
            e_rd = 0; e_wr = 0; e_busy = 0; e_ifv = 0; e_dv = 0;
            e_addr = 8'h00; e_ifd = 8'h00; e_dd = 8'h00;
            if (q.size() > 0) begin
                t = q[0];
                if (c > t.g && c <= t.g + W + 1) begin
                    e_rd   = !t.we;
                    e_wr   = t.we && (c == t.g + W + 1);
                    e_addr = t.addr;
                end
                e_busy = (c > t.g);
                if (c == t.g + W + 2) begin
                    if (t.own) begin e_dv = 1; e_dd = t.expd; end
                    else begin e_ifv = 1; e_ifd = t.expd; end
                end
            end
            chk("mem_ctl", {mem_rd, mem_wr, mem_addr}, {e_rd, e_wr, e_addr});
            if (e_wr) chk("mem_wdata", mem_wdata, t.wdata);
            chk("busy", busy, e_busy);
            chk("valid", {if_valid, d_valid}, {e_ifv, e_dv});
            if (e_ifv) chk("if_rdata", if_rdata, e_ifd);
            if (e_dv)  chk("d_rdata", d_rdata, e_dd);
            if (e_ifv || e_dv) begin
                if (t.we) ref_mem[t.addr] = t.wdata;
                void'(q.pop_front());
            end
            gexp = 0; w = 0;
            if (c >= free_at && (if_req || d_req)) begin
                gexp = 1;
                if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                    w = !last_m;
`else
                    w = (starve_m >= SL) ? 1'b0 : 1'b1;
`endif
                end else begin
                    w = d_req;
                end
            end
            chk("gnt", {if_gnt, d_gnt}, {gexp && !w, gexp && w});
            if (gexp) begin
                t.own   = w;
                t.we    = w ? d_we : 1'b0;
                t.addr  = w ? d_addr : if_addr;
                t.wdata = w ? d_wdata : 8'h00;
                t.expd  = t.we ? 8'h00 : ref_mem[t.addr];
                t.g     = c;
                q.push_back(t);
                glog.push_back(w);
                free_at = c + W + 3;
                if (w && if_req) starve_m++; else starve_m = 0;
                last_m = w;
            end
        end
    end

    function automatic logic [7:0] rand_addr();
        logic [7:0] a;
        a = 8'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = a | 8'hF8;
        return a;
    endfunction

    function automatic logic [15:0] pack_log();
        logic [15:0] v;
        v = 16'h0;
        foreach (glog[i]) v = {v[14:0], glog[i]};
        return v;
    endfunction

    // Issue n_if fetches and n_d data requests, holding each req until granted.
    task automatic run(input int n_if, input int n_d);
        int k;
        bit gi, gd;
        if_req = (n_if > 0);
        d_req  = (n_d > 0);
        for (k = 0; k < 300 && (n_if > 0 || n_d > 0); k++) begin
            @(negedge clk); gi = if_gnt; gd = d_gnt;
            @(posedge clk); #1;
            if (gi) begin
                n_if--;
                if (n_if <= 0) if_req = 1'b0;
                if_addr = 8'($urandom);
            end
            if (gd) begin
                n_d--;
                if (n_d <= 0) d_req = 1'b0;
                d_addr  = rand_addr();
                d_wdata = 8'($urandom);
                d_we    = 1'($urandom_range(0, 1));
            end
        end
        chk("run_timeout", (n_if > 0 || n_d > 0), 0);
        if_req = 1'b0; d_req = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        int k, g2, v2, rdn, bn, rd1;
        bit gi, gd;
        logic [7:0] dat;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom); ref_mem[i] = mem[i]; mem2[i] = 8'($urandom);
        end
        mem[3] = 8'hA7; ref_mem[3] = 8'hA7; mem2[8'h80] = 8'h3C;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req2 = 0; if_addr2 = 0; d_req2 = 0; d_we2 = 0; d_addr2 = 0; d_wdata2 = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_port_outs", {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, busy}, 0);
        chk("rst_mem_outs", {mem_addr, mem_wdata, mem_rd, mem_wr}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fetch of preloaded byte
        if_addr = 8'h03;
        run(1, 0);

        // simultaneous: data first, fetch three cycles later
        glog.delete();
        if_addr = 8'h40; d_addr = 8'h20; d_we = 1'b0;
        run(1, 1);
        chk("simul_len", glog.size(), 2);
        chk("simul_order", pack_log(), 16'h0002);

        // both held continuously
        glog.delete();
        d_we = 1'b0; d_addr = 8'h21;
        run(2, 6);
        chk("starve_len", glog.size(), 8);
`ifdef MEM_ARB_RR_EN
        chk("starve_order", pack_log(), 16'h00AF);
`else
        chk("starve_order", pack_log(), 16'h00EE);
`endif

        // store then fetch at top address
        d_we = 1'b1; d_addr = 8'hFF; d_wdata = 8'hC3;
        run(0, 1);
        if_addr = 8'hFF;
        run(1, 0);
        chk("mem_ff", mem[8'hFF], 8'hC3);

        // reset in the middle of a store
        mem[8'h10] = 8'h11; ref_mem[8'h10] = 8'h11;
        d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h5A; d_req = 1'b1;
        gd = 0;
        for (k = 0; k < 20 && !gd; k++) begin
            @(negedge clk); gd = d_gnt;
        end
        chk("rst_test_gnt", gd, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_port_outs", {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, busy}, 0);
        chk("midrst_mem_outs", {mem_addr, mem_wdata, mem_rd, mem_wr}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_write", mem[8'h10], 8'h11);

        // random traffic with withdrawals and back-to-back requests
        for (k = 0; k < 500; k++) begin
            @(negedge clk); gi = if_gnt; gd = d_gnt;
            @(posedge clk); #1;
            if (if_req) begin
                if (gi) begin if_req = 1'($urandom_range(0, 1)); if_addr = rand_addr(); end
                else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
            end else if ($urandom_range(0, 9) < 4) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
            if (d_req) begin
                if (gd) begin
                    d_req = 1'($urandom_range(0, 1)); d_addr = rand_addr();
                    d_we = 1'($urandom_range(0, 1)); d_wdata = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
            end else if ($urandom_range(0, 9) < 4) begin
                d_req = 1'b1; d_addr = rand_addr();
                d_we = 1'($urandom_range(0, 1)); d_wdata = 8'($urandom);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // WAIT_CYCLES=2 instance: load from 0x80
        d_addr2 = 8'h80; d_we2 = 1'b0; d_req2 = 1'b1;
        g2 = -1; v2 = -1; rdn = 0; bn = 0; rd1 = -1; dat = 8'h00;
        for (k = 0; k < 16; k++) begin
            @(negedge clk);
            if (d_gnt2 && g2 < 0) g2 = k;
            if (mem_rd2) begin rdn++; if (rd1 < 0) rd1 = k; end
            if (busy2) bn++;
            if (d_valid2) begin v2 = k; dat = d_rdata2; end
            @(posedge clk); #1;
            if (g2 >= 0) d_req2 = 1'b0;
        end
        chk("w2_gnt_seen", (g2 >= 0), 1);
        chk("w2_rd_cycles", rdn, 3);
        chk("w2_rd_start", rd1 - g2, 1);
        chk("w2_valid_lat", v2 - g2, 4);
        chk("w2_busy_cycles", bn, 4);
        chk("w2_data", dat, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter for the unified 256x8 program/data memory.
- Shares the single memory port between two requesters: the instruction-fetch port (PC) and the data port (load/store).
- Accepts at most one transaction at a time and drives the memory's address, write-data, read-enable and write-enable.
- Returns read data with a valid pulse, replacing the direct combinational PC/memRead/memWrite hookup.

Parameters:
- WAIT_CYCLES, 0: extra memory access cycles beyond one; ACCESS lasts WAIT_CYCLES+1 cycles.
- STARVE_LIMIT, 3: consecutive data grants allowed while fetch waits; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  8  fetch address (PC).
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  8  fetched instruction byte.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  8  data address.
- d_wdata  in  8  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  8  load data; 0 on store acknowledge.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  memory write data.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  8  memory read data (combinational from mem_addr).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0; starvation counter 0; wait counter 0.
  - Any in-flight transaction is dropped; no gnt or valid is issued for it after reset is released.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - If any req is high, pick a winner and register its addr/we/wdata.
  - Pulse that port's gnt in the same cycle; next state is ACCESS.
  - No req: stay in IDLE with outputs quiet.
- Arbitration (default):
  - Data beats fetch.
  - If STARVE_LIMIT consecutive data grants have occurred while if_req was high at each, the next contested grant goes to fetch.
  - The starvation counter clears on any fetch grant and on any data grant with if_req low.
- ACCESS:
  - mem_addr and mem_wdata hold the registered values.
  - mem_rd is high for all WAIT_CYCLES+1 cycles on a read.
  - mem_wr is high only on the final ACCESS cycle on a write.
  - On the final cycle, mem_rdata is registered; next state is RESP.
- RESP:
  - Pulse the owner's valid for exactly one cycle with its rdata (0 for a store).
  - mem_rd, mem_wr and mem_addr return to 0.
  - Next state is IDLE.
- Latency: gnt at cycle T; valid at T+WAIT_CYCLES+2. Minimum grant-to-grant spacing is WAIT_CYCLES+3 cycles.
- Handshake rules:
  - A req dropped before its gnt is withdrawn, with no side effect.
  - After gnt the requester may drop or change req, addr and wdata; the registered copies are used.
  - A req held high after valid is a new request.
- Ordering: accesses are strictly serialized in grant order. A fetch granted after a store to the same address reads the stored value.
- Both outputs of a pair never pulse together: if_gnt and d_gnt are never high in the same cycle, nor are if_valid and d_valid.
- Addresses are 8-bit with no wrap logic; 0xFF is a legal address.

Optional Feature:
- MEM_ARB_RR_EN defined: the starvation counter is removed and arbitration is round-robin. A contested grant goes to the port not granted last; after reset, data has priority.
- MEM_ARB_RR_EN undefined: fixed data priority with the STARVE_LIMIT bound, as above.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - owner encoding OWN_IF=1'b0, OWN_D=1'b1;
  - address/data width constant 8.
- One natural sub-module: mem_arb_pick, the combinational winner select plus the starvation/round-robin state register.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: d_req store 0x5A to 0x10, assert rst_n=0 during ACCESS.
  - Required: all outputs 0 immediately, no d_valid after release, mem_wr never pulsed.
- Fetch only, WAIT_CYCLES=0:
  - Stimulus: mem[0x03]=0xA7, if_req with if_addr=0x03.
  - Required: if_gnt at T, mem_rd high at T+1, if_valid with if_rdata=0xA7 at T+2.
- Simultaneous requests:
  - Stimulus: if_req and d_req (load 0x20) in the same cycle.
  - Required: d_gnt first; if_gnt 3 cycles later.
- Starvation, STARVE_LIMIT=3:
  - Stimulus: d_req and if_req held continuously.
  - Required: grant order D,D,D,IF,D,D,D,IF.
- Store then fetch, same address:
  - Stimulus: store 0xC3 to 0xFF, then fetch 0xFF.
  - Required: d_valid with d_rdata=0; if_rdata=0xC3.
- WAIT_CYCLES=2:
  - Stimulus: load from 0x80.
  - Required: mem_rd high 3 cycles; d_valid at gnt+4; busy high 4 cycles.
